// File: rtl/tx_msg_sequencer.sv
// tx_msg_sequencer: streams a BaseAddr/Length window of a byte memory into the UART TX handshake, one-shot or repeating.
// Optional macro TXSEQ_CRLF_EN appends 8'h0D 8'h0A to every message before Done.
module tx_msg_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int PERIOD = 50000000,
    parameter int CNT_W  = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Repeat,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Length,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    input  logic              TxEmpty,
    output logic              XMitGo,
    output logic [DATA_W-1:0] TxData,
    output logic              Busy,
    output logic              Done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, WAIT, FINISH, PAUSE} state_t;
    localparam logic [CNT_W-1:0] last_cnt = CNT_W'(PERIOD - 1);
    state_t            state, state_n, start_state;
    logic [ADDR_W-1:0] base, base_n, len, len_n, idx, idx_n, addr_n, msg_base, msg_len;
    logic [DATA_W-1:0] data_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              go_n, done_n, restart;
`ifdef TXSEQ_CRLF_EN
    logic [1:0]        phase, phase_n;
`endif
    assign Busy = state != IDLE;
    assign msg_base = state == IDLE ? BaseAddr : base;
    assign msg_len = state == IDLE ? Length : len;
    assign restart = state == IDLE ? Start : (state == PAUSE && Repeat && cnt == last_cnt);
`ifdef TXSEQ_CRLF_EN
    assign start_state = msg_len == '0 ? LOAD : FETCH;
`else
    assign start_state = msg_len == '0 ? FINISH : FETCH;
`endif
    // Next-state and next-output decode; each register holds unless its state moves it.
    always_comb begin
        state_n = state;
        base_n = base;
        len_n = len;
        idx_n = idx;
        cnt_n = cnt;
        addr_n = MemAddr;
        data_n = TxData;
        go_n = XMitGo;
        done_n = 1'b0;
`ifdef TXSEQ_CRLF_EN
        phase_n = phase;
`endif
        if (restart) begin
            state_n = start_state;
            base_n = msg_base;
            len_n = msg_len;
            idx_n = '0;
            addr_n = msg_base;
`ifdef TXSEQ_CRLF_EN
            phase_n = msg_len == '0 ? 2'd1 : 2'd0;
`endif
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                FETCH: state_n = LOAD;
                LOAD: if (TxEmpty) begin
`ifdef TXSEQ_CRLF_EN
                    data_n = phase == 2'd0 ? MemData : phase == 2'd1 ? DATA_W'(8'h0D) : DATA_W'(8'h0A);
`else
                    data_n = MemData;
`endif
                    go_n = 1'b1;
                    state_n = SEND;
                end
                SEND: if (!TxEmpty) begin
                    go_n = 1'b0;
                    idx_n = idx + 1'b1;
                    state_n = WAIT;
                end
                WAIT: if (TxEmpty) begin
`ifdef TXSEQ_CRLF_EN
                    if (phase == 2'd2) state_n = FINISH;
                    else if (phase == 2'd1 || idx == len) begin
                        phase_n = phase + 2'd1;
                        state_n = LOAD;
                    end else begin
                        addr_n = base + idx;
                        state_n = FETCH;
                    end
`else
                    if (idx == len) state_n = FINISH;
                    else begin
                        addr_n = base + idx;
                        state_n = FETCH;
                    end
`endif
                end
                FINISH: begin
                    done_n = 1'b1;
                    cnt_n = '0;
                    state_n = Repeat ? PAUSE : IDLE;
                end
                PAUSE: begin
                    cnt_n = cnt + 1'b1;
                    state_n = Repeat ? PAUSE : IDLE;
                end
                default: begin
                    state_n = IDLE;
                    go_n = 1'b0;
                end
            endcase
        end
    end
    // State and output registers; Reset aborts any message in progress.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            base <= '0;
            len <= '0;
            idx <= '0;
            cnt <= '0;
            MemAddr <= '0;
            TxData <= '0;
            XMitGo <= 1'b0;
            Done <= 1'b0;
`ifdef TXSEQ_CRLF_EN
            phase <= 2'd0;
`endif
        end else begin
            state <= state_n;
            base <= base_n;
            len <= len_n;
            idx <= idx_n;
            cnt <= cnt_n;
            MemAddr <= addr_n;
            TxData <= data_n;
            XMitGo <= go_n;
            Done <= done_n;
`ifdef TXSEQ_CRLF_EN
            phase <= phase_n;
`endif
        end
    end
endmodule

// File: tb/tb_tx_msg_sequencer.sv
// tb_tx_msg_sequencer: scoreboard bench for tx_msg_sequencer with a paced UART model and synchronous memory.
`timescale 1ns/1ps
module tb_tx_msg_sequencer;
    localparam int PER = 10;
`ifdef TXSEQ_CRLF_EN
    localparam int crlf_n = 2;
`else
    localparam int crlf_n = 0;
`endif
    localparam int AUTO = 0, HOLD1 = 1, HOLD0 = 2;
    logic       Clock = 0, Reset = 1, Start = 0, Repeat = 0, TxEmpty = 1;
    logic [7:0] BaseAddr = 0, Length = 0, MemData = 0;
    logic [7:0] MemAddr, TxData;
    logic       XMitGo, Busy, Done;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int checks = 0, errors = 0;
    int mode = HOLD1, cyc = 0, sent = 0, done_cnt = 0, last_done = 0, gap = -1;
    int drop_cnt = 0, busy_cnt = 0, s0 = 0, d0 = 0;
    logic go_d = 0, fall_chk = 0, done_d = 0, gap_arm = 0;

    tx_msg_sequencer #(.DATA_W(8), .ADDR_W(8), .PERIOD(PER), .CNT_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Repeat(Repeat),
        .BaseAddr(BaseAddr), .Length(Length), .MemAddr(MemAddr), .MemData(MemData),
        .TxEmpty(TxEmpty), .XMitGo(XMitGo), .TxData(TxData), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // One-cycle synchronous read memory.
    always @(posedge Clock) MemData <= mem[MemAddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // UART model and scoreboard: paces TxEmpty, pops an expected byte on each new XMitGo, tracks Done.
    always @(negedge Clock) begin
        cyc++;
        if (fall_chk) begin
            chk("go_drop", 32'(XMitGo), 32'd0);
            fall_chk = 0;
        end
        if (Done) begin
            chk("done_pulse", 32'(done_d), 32'd0);
            done_cnt++;
            last_done = cyc;
            gap_arm = 1;
        end
        done_d = Done;
        if (mode == HOLD1) TxEmpty = 1'b1;
        else if (mode == HOLD0) TxEmpty = 1'b0;
        else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) TxEmpty = 1'b1;
        end else if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) begin
                TxEmpty = 1'b0;
                busy_cnt = 20;
                fall_chk = 1;
            end
        end else TxEmpty = 1'b1;
        if (XMitGo && !go_d) begin
            sent++;
            if (gap_arm) begin
                gap = cyc - last_done;
                gap_arm = 0;
            end
            if (exp_q.size() > 0) chk("txdata", 32'(TxData), 32'(exp_q.pop_front()));
            if (mode == AUTO) drop_cnt = 2;
        end
        go_d = XMitGo;
    end

    task automatic push_msg(input logic [7:0] b, input logic [7:0] n);
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[8'(int'(b) + i)]);
`ifdef TXSEQ_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic start_msg(input logic [7:0] b, input logic [7:0] n);
        BaseAddr = b;
        Length = n;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        chk("done_wait", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic mark();
        s0 = sent;
        d0 = done_cnt;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h10] = 8'h48;
        mem[8'h11] = 8'h45;
        mem[8'h12] = 8'h4C;
        mem[8'h13] = 8'h4C;
        mem[8'h14] = 8'h4F;
        repeat (3) @(negedge Clock);
        chk("rst_go", 32'(XMitGo), 32'd0);
        chk("rst_txdata", 32'(TxData), 32'd0);
        chk("rst_addr", 32'(MemAddr), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        Reset = 0;
        mode = AUTO;
        repeat (2) @(negedge Clock);
        // HELLO message through the paced UART
        mark();
        push_msg(8'h10, 8'd5);
        start_msg(8'h10, 8'd5);
        wait_done(d0 + 1);
        repeat (3) @(negedge Clock);
        chk("hello_nbytes", 32'(sent - s0), 32'(5 + crlf_n));
        chk("hello_qleft", 32'(exp_q.size()), 32'd0);
        chk("hello_ndone", 32'(done_cnt - d0), 32'd1);
        chk("hello_idle", 32'(Busy), 32'd0);
        // latency with TxEmpty held high, then reset while in SEND
        mode = HOLD1;
        @(negedge Clock);
        exp_q.push_back(mem[8'h20]);
        start_msg(8'h20, 8'd3);
        chk("lat_addr", 32'(MemAddr), 32'h20);
        chk("lat_busy", 32'(Busy), 32'd1);
        @(negedge Clock);
        chk("lat_go_early", 32'(XMitGo), 32'd0);
        @(negedge Clock);
        chk("lat_go", 32'(XMitGo), 32'd1);
        chk("lat_txdata", 32'(TxData), 32'(mem[8'h20]));
        @(negedge Clock);
        Reset = 1;
        @(negedge Clock);
        Reset = 0;
        chk("rst_send_go", 32'(XMitGo), 32'd0);
        chk("rst_send_busy", 32'(Busy), 32'd0);
        chk("rst_send_qleft", 32'(exp_q.size()), 32'd0);
        // address wrap FE, FF, 00, 01
        mode = AUTO;
        repeat (2) @(negedge Clock);
        mark();
        push_msg(8'hFE, 8'd4);
        start_msg(8'hFE, 8'd4);
        chk("wrap_addr0", 32'(MemAddr), 32'hFE);
        wait_done(d0 + 1);
        repeat (3) @(negedge Clock);
        chk("wrap_nbytes", 32'(sent - s0), 32'(4 + crlf_n));
        chk("wrap_qleft", 32'(exp_q.size()), 32'd0);
        chk("wrap_addr_last", 32'(MemAddr), 32'h01);
        // zero-length message
        mark();
`ifdef TXSEQ_CRLF_EN
        push_msg(8'h40, 8'd0);
        start_msg(8'h40, 8'd0);
        wait_done(d0 + 1);
        repeat (3) @(negedge Clock);
`else
        start_msg(8'h40, 8'd0);
        chk("len0_busy", 32'(Busy), 32'd1);
        chk("len0_done_early", 32'(Done), 32'd0);
        @(negedge Clock);
        chk("len0_done", 32'(Done), 32'd1);
        @(negedge Clock);
        chk("len0_idle", 32'(Busy), 32'd0);
        chk("len0_done_end", 32'(Done), 32'd0);
`endif
        chk("len0_nbytes", 32'(sent - s0), 32'(crlf_n));
        chk("len0_qleft", 32'(exp_q.size()), 32'd0);
        // repeat mode: restart PERIOD cycles after Done, then drop Repeat mid-PAUSE
        repeat (2) @(negedge Clock);
        mark();
        Repeat = 1;
        push_msg(8'h10, 8'd2);
        push_msg(8'h10, 8'd2);
        start_msg(8'h10, 8'd2);
        wait_done(d0 + 2);
        chk("rep_gap", 32'(gap), 32'(PER + 2));
        repeat (4) @(negedge Clock);
        Repeat = 0;
        @(negedge Clock);
        chk("rep_stop_busy", 32'(Busy), 32'd0);
        repeat (30) @(negedge Clock);
        chk("rep_nbytes", 32'(sent - s0), 32'(2 * (2 + crlf_n)));
        chk("rep_qleft", 32'(exp_q.size()), 32'd0);
        // Start while busy is ignored; LOAD waits for TxEmpty
        mode = HOLD0;
        repeat (2) @(negedge Clock);
        mark();
        push_msg(8'h10, 8'd1);
        start_msg(8'h10, 8'd1);
        repeat (3) @(negedge Clock);
        chk("hold_go", 32'(XMitGo), 32'd0);
        chk("hold_busy", 32'(Busy), 32'd1);
        start_msg(8'h30, 8'd5);
        repeat (2) @(negedge Clock);
        chk("hold_go2", 32'(XMitGo), 32'd0);
        mode = AUTO;
        wait_done(d0 + 1);
        repeat (3) @(negedge Clock);
        chk("hold_nbytes", 32'(sent - s0), 32'(1 + crlf_n));
        chk("hold_qleft", 32'(exp_q.size()), 32'd0);
        chk("hold_addr", 32'(MemAddr), 32'h10);
        chk("hold_idle", 32'(Busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_msg_sequencer.md
Name: tx_msg_sequencer

Overview:
Parametrised successor to the fixed-length ROM-to-UART transmit driver. Streams a run-time-selected window of a byte memory (base address and length) into the UART transmitter using the XMitGo/TxEmpty handshake. Runs one-shot on Start, or repeats at a programmable cycle interval. Sits between the message ROM/RAM (1-cycle synchronous read) and the UART TX block; the pacing counter is internal, so no external pulser is needed.

Parameters:
DATA_W, 8, width of a message byte / TxData
ADDR_W, 8, memory address width; also width of Length
PERIOD, 50000000, cycles from Done to restart when Repeat=1; must be >=1
CNT_W, 32, width of the pacing counter; must hold PERIOD-1

Ports:
Clock  in  1  system clock, all logic on posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin a message; sampled only in IDLE
Repeat  in  1  1 = auto-restart after PERIOD cycles
BaseAddr  in  ADDR_W  first byte address; latched on Start
Length  in  ADDR_W  byte count; latched on Start; 0 = no memory bytes
MemAddr  out  ADDR_W  read address to memory
MemData  in  DATA_W  read data, valid 1 cycle after MemAddr
TxEmpty  in  1  UART ready (1) / busy (0)
XMitGo  out  1  transmit request to UART
TxData  out  DATA_W  byte presented to UART
Busy  out  1  high in any state except IDLE
Done  out  1  1-cycle pulse when the final byte is accepted

Behaviour:
- Reset: state IDLE; XMitGo=0, TxData=0, MemAddr=0, Done=0, Busy=0, byte index=0, pacing counter=0. A reset mid-message aborts it, and XMitGo is 0 after the reset edge.
- All outputs registered. Busy is decoded from the registered state.
- States:
  - IDLE: on Start, latch BaseAddr/Length, index=0, MemAddr<=BaseAddr, go FETCH. If the latched Length=0 (and CRLF is off), skip to FINISH.
  - FETCH: wait one cycle for memory, go LOAD.
  - LOAD: wait for TxEmpty=1. Then TxData<=MemData, XMitGo<=1, go SEND.
  - SEND: hold XMitGo=1 and TxData stable until TxEmpty=0. Then XMitGo<=0, index++, go WAIT.
  - WAIT: wait for TxEmpty=1. If index==Length, go FINISH. Otherwise MemAddr<=BaseAddr+index (mod 2^ADDR_W wrap), go FETCH.
  - FINISH: Done<=1 for one cycle. If Repeat=1, counter<=0 and go PAUSE; else go IDLE.
  - PAUSE: counter++. When counter==PERIOD-1, restart from FETCH using the latched base/length. If Repeat=0 in any PAUSE cycle, go IDLE immediately.
- Latency: Start sampled at edge k, in IDLE, with TxEmpty=1 → MemAddr valid after k; TxData/XMitGo valid after edge k+2.
- Start while Busy is ignored. BaseAddr/Length changes while Busy have no effect until the next Start.
- Length is unsigned. A message of 2^ADDR_W-1 bytes is legal. Address wraps from max to 0.
- Repeat is sampled only in FINISH and PAUSE.
- Illegal state encodings recover to IDLE with XMitGo=0.

Optional Feature:
TXSEQ_CRLF_EN
- Defined: after the last memory byte (or immediately, if Length=0), sends 8'h0D then 8'h0A. These bytes come from constants via LOAD/SEND/WAIT without a memory fetch. Done pulses after the 8'h0A is accepted.
- Undefined: no appended bytes, and Length=0 goes straight to FINISH.

Test Plan:
- Memory[0x10..0x14]="HELLO", BaseAddr=0x10, Length=5, Start pulse, UART model drops TxEmpty 2 cycles after XMitGo and raises it 20 cycles later → TxData sequence 48,45,4C,4C,4F; XMitGo low within 1 cycle of each TxEmpty fall; one Done pulse; back to IDLE.
- Latency: TxEmpty held 1, Start at edge k → MemAddr=BaseAddr after k; XMitGo=1 and TxData=mem[BaseAddr] after edge k+2.
- Wrap: BaseAddr=0xFE, Length=4 → MemAddr sequence FE, FF, 00, 01; four bytes sent.
- Length=0, CRLF undefined → no XMitGo, Done 2 cycles after Start. CRLF defined → TxData sequence 0D, 0A, then Done.
- Repeat=1, PERIOD=10, Length=2 → message restarts 10 cycles after each Done. Deassert Repeat mid-PAUSE → IDLE next edge, no further XMitGo.
- Reset asserted while in SEND → XMitGo=0, Busy=0 after the edge. Start while Busy and TxEmpty held 0 in LOAD → Start ignored, XMitGo stays 0 until TxEmpty=1.
